// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, FSM encoding, default sizes.
// Pure declarations; no logic, no latency, no flow control.
package keypad_pkg;

    localparam int DIGITS_DEF = 4;
    localparam int VAL_W_DEF  = 14;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_BACK  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_entry_bcd_to_bin.sv
// BCD to binary converter, combinational (zero latency), no flow control.
// Horner form from the most significant digit: acc = acc*10 + digit, with x10 as shift-add.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic [DIGITS*4-1:0] bcd,
    output logic [VAL_W-1:0]    value
);

    always_comb begin
        value = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            value = (value << 3) + (value << 1) + VAL_W'(bcd[i*4 +: 4]);
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit collector: builds a DIGITS-digit BCD entry and commits it as binary; enter -> valid is 2 cycles.
// No backpressure: keys that cannot be taken are flagged on key_reject. Optional backspace: KEYPAD_BACKSPACE_EN.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS         = DIGITS_DEF,
    parameter int VAL_W          = VAL_W_DEF,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             target_sel,
    input  logic             entry_enable,
    output logic [VAL_W-1:0] password_out,
    output logic             password_valid,
    output logic [VAL_W-1:0] new_password_out,
    output logic             new_password_valid,
    output logic [2:0]       digit_count,
    output logic             entry_busy,
    output logic             key_reject,
    output logic             entry_error,
    output logic             timeout_pulse
);

    localparam int         BUF_W    = DIGITS * 4;
    localparam int         TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] CNT_FULL = 3'(DIGITS);

    state_t             state, state_nxt;
    logic [BUF_W-1:0]   bcd_buf;
    logic [2:0]         count;
    logic [TMR_W-1:0]   timer;
    logic               target_q;
    logic [VAL_W-1:0]   commit_val;
    logic               expired;

    logic act_shift, act_back, act_clear, act_reload, act_latch, act_commit;
    logic rej_nxt, err_nxt, tmo_nxt;

    assign expired = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_bcd_to_bin (
        .bcd    (bcd_buf),
        .value  (commit_val)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        act_shift  = 1'b0;
        act_back   = 1'b0;
        act_clear  = 1'b0;
        act_reload = 1'b0;
        act_latch  = 1'b0;
        act_commit = 1'b0;
        rej_nxt    = 1'b0;
        err_nxt    = 1'b0;
        tmo_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    if (!entry_enable) begin
                        rej_nxt = 1'b1;
                    end else if (is_digit(key_code)) begin
                        act_shift  = 1'b1;
                        act_reload = 1'b1;
                        state_nxt  = ST_ENTRY;
                    end else if (key_code == KEY_ENTER) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                if (!entry_enable) begin
                    act_clear = 1'b1;
                    rej_nxt   = key_valid;
                    state_nxt = ST_IDLE;
                end else if (key_valid) begin
                    // any key in the expiry cycle pre-empts the timeout
                    if (is_digit(key_code)) begin
                        if (count < CNT_FULL) begin
                            act_shift  = 1'b1;
                            act_reload = 1'b1;
                        end else begin
                            rej_nxt = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        act_clear = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (key_code == KEY_ENTER) begin
                        if (count == CNT_FULL) begin
                            act_latch = 1'b1;
                            state_nxt = ST_COMMIT;
                        end else begin
                            err_nxt    = 1'b1;
                            act_reload = 1'b1;
                        end
`ifdef KEYPAD_BACKSPACE_EN
                    end else if (key_code == KEY_BACK) begin
                        act_back   = 1'b1;
                        act_reload = 1'b1;
                        if (count == 3'd1) state_nxt = ST_IDLE;
`endif
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end else if (expired) begin
                    tmo_nxt   = 1'b1;
                    act_clear = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // commit always completes, even with entry_enable low
                act_commit = 1'b1;
                rej_nxt    = key_valid;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        entry_busy = (state == ST_ENTRY);
    end

    assign digit_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_buf            <= '0;
            count              <= '0;
            timer              <= '0;
            target_q           <= 1'b0;
            password_out       <= '0;
            password_valid     <= 1'b0;
            new_password_out   <= '0;
            new_password_valid <= 1'b0;
            key_reject         <= 1'b0;
            entry_error        <= 1'b0;
            timeout_pulse      <= 1'b0;
        end else begin
            key_reject         <= rej_nxt;
            entry_error        <= err_nxt;
            timeout_pulse      <= tmo_nxt;
            password_valid     <= 1'b0;
            new_password_valid <= 1'b0;

            if (act_clear || act_commit) begin
                bcd_buf <= '0;
                count   <= '0;
            end else if (act_shift) begin
                bcd_buf <= (bcd_buf << 4) | BUF_W'(key_code);
                count   <= count + 3'd1;
            end else if (act_back) begin
                bcd_buf <= bcd_buf >> 4;
                count   <= count - 3'd1;
            end

            // timer counts only key-free cycles, so a rejected key neither reloads nor advances it
            if (act_reload || act_clear || state != ST_ENTRY) timer <= '0;
            else if (!key_valid)                              timer <= timer + 1'b1;

            if (act_latch) target_q <= target_sel;

            if (act_commit) begin
                if (target_q) begin
                    new_password_out   <= commit_val;
                    new_password_valid <= 1'b1;
                end else begin
                    password_out       <= commit_val;
                    password_valid     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed vector table, timeout/reset sequences, random keys vs a queue-based model.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam int TMO   = 12;
    localparam int VAL_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             target_sel;
    logic             entry_enable;
    logic [VAL_W-1:0] password_out;
    logic             password_valid;
    logic [VAL_W-1:0] new_password_out;
    logic             new_password_valid;
    logic [2:0]       digit_count;
    logic             entry_busy;
    logic             key_reject;
    logic             entry_error;
    logic             timeout_pulse;

    always #5 clk = ~clk;

    keypad_entry #(
        .DIGITS         (4),
        .VAL_W          (VAL_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .key_valid          (key_valid),
        .key_code           (key_code),
        .target_sel         (target_sel),
        .entry_enable       (entry_enable),
        .password_out       (password_out),
        .password_valid     (password_valid),
        .new_password_out   (new_password_out),
        .new_password_valid (new_password_valid),
        .digit_count        (digit_count),
        .entry_busy         (entry_busy),
        .key_reject         (key_reject),
        .entry_error        (entry_error),
        .timeout_pulse      (timeout_pulse)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model: digits held newest-first (index 0 = least significant), value by powers of ten.
    int q[$];
    bit m_entry, m_commit, m_tgt;
    int idle_cnt;
    int e_pw, e_npw;
    bit e_pwv, e_npwv, e_rej, e_err, e_tmo;

    function automatic int q_value();
        int v = 0;
        int p = 1;
        foreach (q[i]) begin
            v += q[i] * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_entry = 0; m_commit = 0; m_tgt = 0; idle_cnt = 0;
        e_pw = 0; e_npw = 0;
        e_pwv = 0; e_npwv = 0; e_rej = 0; e_err = 0; e_tmo = 0;
    endfunction

    function automatic void model_step(bit kv, bit [3:0] kc, bit ts, bit en);
        e_pwv = 0; e_npwv = 0; e_rej = 0; e_err = 0; e_tmo = 0;
        if (m_commit) begin
            if (m_tgt) begin e_npw = q_value(); e_npwv = 1; end
            else       begin e_pw  = q_value(); e_pwv  = 1; end
            q.delete();
            m_commit = 0;
            e_rej = kv;
        end else if (!m_entry) begin
            if (kv) begin
                if (!en) e_rej = 1;
                else if (kc <= 4'd9) begin
                    q.push_front(int'(kc));
                    idle_cnt = 0;
                    m_entry = 1;
                end else if (kc == 4'hB) e_err = 1;
            end
        end else if (!en) begin
            q.delete();
            m_entry = 0;
            e_rej = kv;
        end else if (kv) begin
            if (kc <= 4'd9) begin
                if (q.size() < 4) begin q.push_front(int'(kc)); idle_cnt = 0; end
                else e_rej = 1;
            end else if (kc == 4'hA) begin
                q.delete();
                m_entry = 0;
            end else if (kc == 4'hB) begin
                if (q.size() == 4) begin m_tgt = ts; m_commit = 1; m_entry = 0; end
                else begin e_err = 1; idle_cnt = 0; end
`ifdef KEYPAD_BACKSPACE_EN
            end else if (kc == 4'hC) begin
                void'(q.pop_front());
                idle_cnt = 0;
                if (q.size() == 0) m_entry = 0;
`endif
            end else begin
                e_rej = 1;
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                e_tmo = 1;
                q.delete();
                m_entry = 0;
            end
        end
    endfunction

    task automatic compare_model();
        chk("model_values", {password_out, new_password_out}, {14'(e_pw), 14'(e_npw)});
        chk("model_strobes", {password_valid, new_password_valid, key_reject, entry_error, timeout_pulse},
            {e_pwv, e_npwv, e_rej, e_err, e_tmo});
        chk("model_count", {digit_count, entry_busy}, {3'(q.size()), m_entry});
    endtask

    task automatic cycle(input bit kv, input bit [3:0] kc, input bit ts, input bit en);
        key_valid = kv; key_code = kc; target_sel = ts; entry_enable = en;
        @(posedge clk);
        model_step(kv, kc, ts, en);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit       kv;
        bit [3:0] kc;
        bit       ts;
        bit       en;
        bit [2:0] cnt;
        bit       busy, rej, err, pwv, npwv;
        int       pw, npw;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit kv, bit [3:0] kc, bit ts, bit en, bit [2:0] cnt, bit busy,
                                bit rej, bit err, bit pwv, bit npwv, int pw, int npw);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ts = ts; v.en = en; v.cnt = cnt; v.busy = busy;
        v.rej = rej; v.err = err; v.pwv = pwv; v.npwv = npwv; v.pw = pw; v.npw = npw;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1; key_valid = 0; key_code = 0; target_sel = 0; entry_enable = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {password_out, new_password_out, password_valid, new_password_valid,
                            digit_count, entry_busy, key_reject, entry_error, timeout_pulse}, 64'd0);
        reset = 0;

        //   kv kc    ts en  cnt busy rej err pwv npwv  pw    npw
        add(1, 4'hB, 0, 1,  0,  0,   0,  1,  0,  0,    0,    0);
        add(1, 4'hA, 0, 1,  0,  0,   0,  0,  0,  0,    0,    0);
        for (int i = 1; i <= 4; i++) add(1, 4'd1, 0, 1, 3'(i), 1, 0, 0, 0, 0, 0, 0);
        add(1, 4'hB, 0, 1,  4,  0,   0,  0,  0,  0,    0,    0);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  1,  0, 1111,    0);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  0,  0, 1111,    0);
        for (int i = 1; i <= 4; i++) add(1, 4'd2, 1, 1, 3'(i), 1, 0, 0, 0, 0, 1111, 0);
        add(1, 4'hB, 1, 1,  4,  0,   0,  0,  0,  0, 1111,    0);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  0,  1, 1111, 2222);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  0,  0, 1111, 2222);
        add(1, 4'd3, 0, 1,  1,  1,   0,  0,  0,  0, 1111, 2222);
        add(1, 4'd3, 0, 1,  2,  1,   0,  0,  0,  0, 1111, 2222);
        add(1, 4'hB, 0, 1,  2,  1,   0,  1,  0,  0, 1111, 2222);
        add(1, 4'd3, 0, 1,  3,  1,   0,  0,  0,  0, 1111, 2222);
        add(1, 4'd3, 0, 1,  4,  1,   0,  0,  0,  0, 1111, 2222);
        add(1, 4'hB, 0, 1,  4,  0,   0,  0,  0,  0, 1111, 2222);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  1,  0, 3333, 2222);
        for (int i = 1; i <= 4; i++) add(1, 4'(i + 3), 0, 1, 3'(i), 1, 0, 0, 0, 0, 3333, 2222);
        add(1, 4'd8, 0, 1,  4,  1,   1,  0,  0,  0, 3333, 2222);
        add(1, 4'hB, 0, 1,  4,  0,   0,  0,  0,  0, 3333, 2222);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  1,  0, 4567, 2222);
        for (int i = 1; i <= 4; i++) add(1, 4'(i), 0, 1, 3'(i), 1, 0, 0, 0, 0, 4567, 2222);
        add(1, 4'hB, 0, 1,  4,  0,   0,  0,  0,  0, 4567, 2222);
        add(1, 4'd5, 0, 0,  0,  0,   1,  0,  1,  0, 1234, 2222);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'd1, 0, 1,  1,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'd2, 0, 1,  2,  1,   0,  0,  0,  0, 1234, 2222);
        add(0, 4'h0, 0, 0,  0,  0,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'd3, 0, 0,  0,  0,   1,  0,  0,  0, 1234, 2222);
        add(1, 4'd3, 0, 1,  1,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'hA, 0, 1,  0,  0,   0,  0,  0,  0, 1234, 2222);
`ifdef KEYPAD_BACKSPACE_EN
        for (int i = 1; i <= 3; i++) add(1, 4'(i), 0, 1, 3'(i), 1, 0, 0, 0, 0, 1234, 2222);
        add(1, 4'hC, 0, 1,  2,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'd4, 0, 1,  3,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'd5, 0, 1,  4,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'hB, 0, 1,  4,  0,   0,  0,  0,  0, 1234, 2222);
        add(0, 4'h0, 0, 1,  0,  0,   0,  0,  1,  0, 1245, 2222);
`else
        add(1, 4'd1, 0, 1,  1,  1,   0,  0,  0,  0, 1234, 2222);
        add(1, 4'hC, 0, 1,  1,  1,   1,  0,  0,  0, 1234, 2222);
        add(1, 4'hA, 0, 1,  0,  0,   0,  0,  0,  0, 1234, 2222);
`endif

        foreach (vecs[i]) begin
            cycle(vecs[i].kv, vecs[i].kc, vecs[i].ts, vecs[i].en);
            chk($sformatf("vec%0d", i),
                {digit_count, entry_busy, key_reject, entry_error, password_valid, new_password_valid,
                 password_out, new_password_out},
                {vecs[i].cnt, vecs[i].busy, vecs[i].rej, vecs[i].err, vecs[i].pwv, vecs[i].npwv,
                 14'(vecs[i].pw), 14'(vecs[i].npw)});
        end

        // Timeout: two digits, then exactly TMO key-free cycles discards them.
        cycle(1, 4'd9, 0, 1);
        cycle(1, 4'd9, 0, 1);
        for (int k = 1; k < TMO; k++) begin
            cycle(0, 4'h0, 0, 1);
            chk("tmo_early", {timeout_pulse, digit_count}, {1'b0, 3'd2});
        end
        cycle(0, 4'h0, 0, 1);
        chk("tmo_fire", {timeout_pulse, digit_count, entry_busy, password_valid, new_password_valid},
            {1'b1, 3'd0, 1'b0, 1'b0, 1'b0});
        cycle(0, 4'h0, 0, 1);
        chk("tmo_single", timeout_pulse, 1'b0);

        // Reset in the COMMIT cycle aborts without a strobe.
        for (int i = 5; i <= 8; i++) cycle(1, 4'(i), 0, 1);
        cycle(1, 4'hB, 0, 1);
        reset = 1; key_valid = 0;
        @(posedge clk);
        model_reset();
        #1;
        chk("reset_commit", {password_valid, password_out, new_password_out, digit_count}, 64'd0);
        reset = 0;
        cycle(0, 4'h0, 0, 1);
        chk("reset_no_strobe", {password_valid, new_password_valid}, 2'b00);

        // Random keys against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit [3:0] kc;
            if ($urandom_range(0, 99) < 3) begin
                r = $urandom_range(TMO - 2, TMO + 3);
                for (int g = 0; g < r; g++) cycle(0, 4'h0, 0, 1);
            end
            r = $urandom_range(0, 9);
            if (r < 6)       kc = 4'($urandom_range(0, 9));
            else if (r < 8)  kc = 4'hB;
            else if (r == 8) kc = 4'hA;
            else             kc = 4'($urandom_range(12, 15));
            cycle($urandom_range(0, 2) == 0, kc, 1'($urandom_range(0, 1)), $urandom_range(0, 49) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
